// File: rtl/ysyx_pkg.sv
// Shared definitions for the ysyx fetch front end: FSM state encodings,
// default reset PC and small address helpers.
package ysyx_pkg;

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_OUT  = 3'd2,
        S_DROP = 3'd3,
        S_ERR  = 3'd4
    } ifuState_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    function automatic logic isAligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ifu_ysyx.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// valid/ready memory channel and hands it to decode with its PC.
module ifu_ysyx
    import ysyx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err,
    output logic [31:0] fetch_err_pc
);

    ifuState_t   state;
    logic [31:0] pc;
    logic [31:0] instReg;
    logic [31:0] instPcReg;
    logic        errFlag;
    logic [31:0] errPc;
    // A misaligned redirect arrived while a response was still owed: drain it, then stop.
    logic        errPending;

    logic reqFire;
    logic redirectOk;
    logic redirectBad;

    assign mem_req_valid = (state == S_REQ) && !rst;
    assign mem_req_addr  = pc;
    assign inst_valid    = (state == S_OUT);
    assign inst          = instReg;
    assign inst_pc       = instPcReg;
    assign fetch_err     = errFlag;
    assign fetch_err_pc  = errPc;

    assign reqFire     = mem_req_valid && mem_req_ready;
    assign redirectOk  = redirect_valid && isAligned(redirect_pc);
    assign redirectBad = redirect_valid && !isAligned(redirect_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            instReg    <= 32'h0;
            instPcReg  <= 32'h0;
            errFlag    <= 1'b0;
            errPc      <= 32'h0;
            errPending <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirectBad) begin
                        errFlag    <= 1'b1;
                        errPc      <= redirect_pc;
                        pc         <= redirect_pc;
                        errPending <= reqFire;
                        state      <= reqFire ? S_DROP : S_ERR;
                    end else if (redirectOk) begin
                        pc    <= redirect_pc;
                        state <= reqFire ? S_DROP : S_REQ;
                    end else if (reqFire) begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (redirectBad) begin
                        errFlag    <= 1'b1;
                        errPc      <= redirect_pc;
                        pc         <= redirect_pc;
                        errPending <= !mem_rsp_valid;
                        state      <= mem_rsp_valid ? S_ERR : S_DROP;
                    end else if (redirectOk) begin
                        // A response landing with the redirect belongs to the old path.
                        pc    <= redirect_pc;
                        state <= mem_rsp_valid ? S_REQ : S_DROP;
                    end else if (mem_rsp_valid) begin
                        if (mem_rsp_err) begin
                            errFlag <= 1'b1;
                            errPc   <= pc;
                            state   <= S_ERR;
                        end else begin
                            instReg   <= mem_rsp_data;
                            instPcReg <= pc;
                            state     <= S_OUT;
                        end
                    end
                end

                S_OUT: begin
                    // A consume coinciding with a redirect still counts; only the next PC changes.
                    if (redirectBad) begin
                        errFlag <= 1'b1;
                        errPc   <= redirect_pc;
                        pc      <= redirect_pc;
                        state   <= S_ERR;
                    end else if (redirectOk) begin
                        pc    <= redirect_pc;
                        state <= S_REQ;
                    end else if (inst_ready) begin
                        pc    <= pc + INST_BYTES;
                        state <= S_REQ;
                    end
                end

                S_DROP: begin
                    if (!errPending && redirectBad) begin
                        errFlag <= 1'b1;
                        errPc   <= redirect_pc;
                        pc      <= redirect_pc;
                    end else if (!errPending && redirectOk) begin
                        pc <= redirect_pc;
                    end

                    if (mem_rsp_valid) begin
                        errPending <= 1'b0;
                        state      <= (errPending || redirectBad) ? S_ERR : S_REQ;
                    end else if (redirectBad) begin
                        errPending <= 1'b1;
                    end
                end

                S_ERR: begin
                    state <= S_ERR;
                end

                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_ysyx.sv
// Directed bench for ifu_ysyx: a small latency-programmable memory model,
// a handshake monitor and hand-computed expectations per scenario.
module tb_ifu_ysyx;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;
    logic [31:0] fetch_err_pc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rspLat = 1;
    int rstViol = 0;
    logic [31:0] errAddr = 32'h0000_0001;

    logic [31:0] reqQ[$];
    int          reqCycQ[$];
    logic [31:0] instQ[$];
    logic [31:0] instPcQ[$];

    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] pendAddr = 32'h0;

    ifu_ysyx dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_err    (mem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err),
        .fetch_err_pc   (fetch_err_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: accepts every handshake, answers rspLat edges later with {addr[15:0], 16'h0013}.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            pend          = 0;
            cnt           = 0;
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    pend          = 0;
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = {pendAddr[15:0], 16'h0013};
                    mem_rsp_err   = (pendAddr == errAddr);
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                pend     = 1;
                cnt      = rspLat;
                pendAddr = mem_req_addr;
            end
        end
    end

    // Handshake monitor, sampled mid-cycle once inputs for the coming edge are settled.
    always begin
        @(negedge clk);
        #3;
        if (rst) begin
            if (mem_req_valid || inst_valid) rstViol++;
        end else begin
            if (mem_req_valid && mem_req_ready) begin
                reqQ.push_back(mem_req_addr);
                reqCycQ.push_back(cyc);
            end
            if (inst_valid && inst_ready) begin
                instQ.push_back(inst);
                instPcQ.push_back(inst_pc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end else begin
            $display("pass %s: %08h", tag, act);
        end
    endtask

    task automatic doReset();
        rstViol        = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
        check("rst_fetch_err_pc", fetch_err_pc, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_viol", rstViol, 0);
        reqQ.delete();
        reqCycQ.delete();
        instQ.delete();
        instPcQ.delete();
        rst = 1'b0;
    endtask

    task automatic waitReqs(input int n);
        int k = 0;
        while (reqQ.size() < n && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (reqQ.size() < n) check("timeout_req", reqQ.size(), n);
    endtask

    task automatic waitInsts(input int n);
        int k = 0;
        while (instQ.size() < n && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (instQ.size() < n) check("timeout_inst", instQ.size(), n);
    endtask

    task automatic waitInstValid();
        int k = 0;
        while (!inst_valid && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!inst_valid) check("timeout_inst_valid", {31'b0, inst_valid}, 32'h1);
    endtask

    task automatic pulseRedirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        clk            = 1'b0;
        rst            = 1'b1;
        mem_req_ready  = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        mem_rsp_err    = 1'b0;

        // Streaming fetch with zero-wait memory: 3-cycle cadence
        rspLat = 1; inst_ready = 1'b1;
        doReset();
        waitReqs(3);
        check("t1_req0", reqQ[0], 32'h8000_0000);
        check("t1_req1", reqQ[1], 32'h8000_0004);
        check("t1_req2", reqQ[2], 32'h8000_0008);
        check("t1_cadence01", reqCycQ[1] - reqCycQ[0], 3);
        check("t1_cadence12", reqCycQ[2] - reqCycQ[1], 3);
        waitInsts(2);
        check("t1_inst_pc0", instPcQ[0], 32'h8000_0000);
        check("t1_inst0", instQ[0], 32'h0000_0013);
        check("t1_inst_pc1", instPcQ[1], 32'h8000_0004);
        check("t1_inst1", instQ[1], 32'h0004_0013);

        // Decode stalls 5 cycles in S_OUT
        inst_ready = 1'b0;
        doReset();
        waitInstValid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("t2_inst_hold", inst, 32'h0000_0013);
            check("t2_pc_hold", inst_pc, 32'h8000_0000);
            check("t2_no_req", {31'b0, mem_req_valid}, 32'h0);
        end
        check("t2_req_count", reqQ.size(), 1);
        inst_ready = 1'b1;
        @(negedge clk);
        #1;
        inst_ready = 1'b0;
        waitReqs(2);
        check("t2_next_req", reqQ[1], 32'h8000_0004);
        check("t2_consumed_once", instQ.size(), 1);

        // Redirect in S_WAIT before the response arrives
        rspLat = 3; inst_ready = 1'b1;
        doReset();
        waitReqs(1);
        pulseRedirect(32'h8000_0100);
        check("t3_drop_no_req", {31'b0, mem_req_valid}, 32'h0);
        waitReqs(2);
        check("t3_req", reqQ[1], 32'h8000_0100);
        waitInsts(1);
        check("t3_inst_pc", instPcQ[0], 32'h8000_0100);
        check("t3_inst", instQ[0], 32'h0100_0013);

        // Redirect in S_WAIT with the response in the same cycle
        rspLat = 1;
        doReset();
        waitReqs(1);
        pulseRedirect(32'h8000_0300);
        check("t3b_req_valid", {31'b0, mem_req_valid}, 32'h1);
        check("t3b_req_addr", mem_req_addr, 32'h8000_0300);
        waitInsts(1);
        check("t3b_inst_pc", instPcQ[0], 32'h8000_0300);

        // Redirect in S_OUT together with a consume
        inst_ready = 1'b0;
        doReset();
        waitInstValid();
        inst_ready = 1'b1;
        pulseRedirect(32'h8000_0200);
        inst_ready = 1'b0;
        check("t4_word_dropped", {31'b0, inst_valid}, 32'h0);
        waitReqs(2);
        check("t4_next_req", reqQ[1], 32'h8000_0200);
        check("t4_consumed_once", instQ.size(), 1);
        check("t4_consumed_pc", instPcQ[0], 32'h8000_0000);

        // Misaligned redirect from S_OUT
        doReset();
        waitInstValid();
        pulseRedirect(32'h8000_0102);
        check("t5_fetch_err", {31'b0, fetch_err}, 32'h1);
        check("t5_fetch_err_pc", fetch_err_pc, 32'h8000_0102);
        repeat (10) @(negedge clk);
        #1;
        check("t5_no_more_req", reqQ.size(), 1);
        check("t5_req_valid", {31'b0, mem_req_valid}, 32'h0);
        check("t5_inst_valid", {31'b0, inst_valid}, 32'h0);
        check("t5_err_sticky", {31'b0, fetch_err}, 32'h1);

        // Misaligned redirect while a response is still owed
        rspLat = 3; inst_ready = 1'b1;
        doReset();
        waitReqs(1);
        pulseRedirect(32'h8000_0006);
        check("t5b_fetch_err", {31'b0, fetch_err}, 32'h1);
        check("t5b_fetch_err_pc", fetch_err_pc, 32'h8000_0006);
        repeat (10) @(negedge clk);
        #1;
        check("t5b_no_more_req", reqQ.size(), 1);
        check("t5b_no_inst", instQ.size(), 0);

        // Memory access fault at 8000_0010
        rspLat = 1; errAddr = 32'h8000_0010;
        doReset();
        waitReqs(5);
        repeat (6) @(negedge clk);
        #1;
        check("t6_fetch_err", {31'b0, fetch_err}, 32'h1);
        check("t6_fetch_err_pc", fetch_err_pc, 32'h8000_0010);
        check("t6_inst_valid", {31'b0, inst_valid}, 32'h0);
        check("t6_inst_count", instQ.size(), 4);
        check("t6_req_count", reqQ.size(), 5);
        errAddr = 32'h0000_0001;

        // Redirect in S_REQ while memory is not ready
        mem_req_ready = 1'b0;
        doReset();
        repeat (2) @(negedge clk);
        #1;
        pulseRedirect(32'h8000_0400);
        check("t7_req_valid", {31'b0, mem_req_valid}, 32'h1);
        check("t7_req_addr", mem_req_addr, 32'h8000_0400);
        mem_req_ready = 1'b1;
        waitReqs(1);
        check("t7_first_req", reqQ[0], 32'h8000_0400);

        // PC wraps past the top of the address space
        inst_ready = 1'b0;
        doReset();
        waitInstValid();
        inst_ready = 1'b1;
        pulseRedirect(32'hFFFF_FFFC);
        waitReqs(3);
        check("t8_req_top", reqQ[1], 32'hFFFF_FFFC);
        check("t8_req_wrap", reqQ[2], 32'h0000_0000);
        waitInsts(2);
        check("t8_inst_pc_top", instPcQ[1], 32'hFFFF_FFFC);
        check("t8_inst_top", instQ[1], 32'hFFFC_0013);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
